// File: rtl/sine_duty_seq.sv
// sine_duty_seq
//   Sample sequencer feeding an 8-bit PWM comparator. A prescaler advances an
//   8-bit phase; the phase is folded onto a 65-entry quarter-wave sine table
//   to produce a rectified sine. The looked-up sample is held as "pending" and
//   handed to the PWM stage only on period_start, so a PWM period never sees a
//   duty change. Output runs as bursts of CYCLES_PER_BURST phase sweeps, each
//   burst followed by a PAUSE_CLKS pause.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   enable        run request (level)
//   period_start  one-cycle pulse from the PWM stage at its counter wrap
//   duty          duty value to the PWM comparator
//   duty_valid    one-cycle pulse in the cycle duty takes a new value
//   theta         current phase
//   state         00 IDLE, 01 RUN, 10 PAUSE
//   burst_done    one-cycle pulse on entry to PAUSE
module sine_duty_seq #(
    parameter int unsigned STEP_DIV         = 5000000,
    parameter int unsigned CYCLES_PER_BURST = 2,
    parameter int unsigned PAUSE_CLKS       = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       period_start,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic [7:0] theta,
    output logic [1:0] state,
    output logic       burst_done
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CW = (CYCLES_PER_BURST > 0) ? $clog2(CYCLES_PER_BURST + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CYC_TARGET = CW'(CYCLES_PER_BURST);
    // PAUSE_CLKS=0 still spends one clock in PAUSE.
    localparam logic [31:0]   PAUSE_LAST = (PAUSE_CLKS == 0) ? 32'd0 : 32'(PAUSE_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t         st_q, st_d;
    logic [7:0]     theta_q, theta_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [31:0]    pause_q, pause_d;
    logic           bd_d;
    logic [7:0]     pend_q, pend_d;
    logic [6:0]     idx;

    // Quarter-wave table: round(255*sin(pi*i/128)), i = 0..64.
    function automatic logic [7:0] sine_rom(input logic [6:0] i);
        logic [7:0] v;
        case (i)
            7'd0:  v = 8'd0;   7'd1:  v = 8'd6;   7'd2:  v = 8'd13;  7'd3:  v = 8'd19;
            7'd4:  v = 8'd25;  7'd5:  v = 8'd31;  7'd6:  v = 8'd37;  7'd7:  v = 8'd44;
            7'd8:  v = 8'd50;  7'd9:  v = 8'd56;  7'd10: v = 8'd62;  7'd11: v = 8'd68;
            7'd12: v = 8'd74;  7'd13: v = 8'd80;  7'd14: v = 8'd86;  7'd15: v = 8'd92;
            7'd16: v = 8'd98;  7'd17: v = 8'd103; 7'd18: v = 8'd109; 7'd19: v = 8'd115;
            7'd20: v = 8'd120; 7'd21: v = 8'd126; 7'd22: v = 8'd131; 7'd23: v = 8'd136;
            7'd24: v = 8'd142; 7'd25: v = 8'd147; 7'd26: v = 8'd152; 7'd27: v = 8'd157;
            7'd28: v = 8'd162; 7'd29: v = 8'd167; 7'd30: v = 8'd171; 7'd31: v = 8'd176;
            7'd32: v = 8'd180; 7'd33: v = 8'd185; 7'd34: v = 8'd189; 7'd35: v = 8'd193;
            7'd36: v = 8'd197; 7'd37: v = 8'd201; 7'd38: v = 8'd205; 7'd39: v = 8'd208;
            7'd40: v = 8'd212; 7'd41: v = 8'd215; 7'd42: v = 8'd219; 7'd43: v = 8'd222;
            7'd44: v = 8'd225; 7'd45: v = 8'd228; 7'd46: v = 8'd231; 7'd47: v = 8'd233;
            7'd48: v = 8'd236; 7'd49: v = 8'd238; 7'd50: v = 8'd240; 7'd51: v = 8'd242;
            7'd52: v = 8'd244; 7'd53: v = 8'd246; 7'd54: v = 8'd247; 7'd55: v = 8'd249;
            7'd56: v = 8'd250; 7'd57: v = 8'd251; 7'd58: v = 8'd252; 7'd59: v = 8'd253;
            7'd60: v = 8'd254; 7'd61: v = 8'd254; 7'd62: v = 8'd255; 7'd63: v = 8'd255;
            default: v = 8'd255;
        endcase
        return v;
    endfunction

    // Fold the phase onto the quarter wave; bit 7 is ignored (rectified).
    assign idx = theta_q[6] ? (7'd64 - {1'b0, theta_q[5:0]}) : {1'b0, theta_q[5:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= IDLE;
            theta_q    <= '0;
            presc_q    <= '0;
            cyc_q      <= '0;
            pause_q    <= '0;
            burst_done <= 1'b0;
            pend_q     <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            st_q       <= st_d;
            theta_q    <= theta_d;
            presc_q    <= presc_d;
            cyc_q      <= cyc_d;
            pause_q    <= pause_d;
            burst_done <= bd_d;
            pend_q     <= pend_d;
            // The PWM stage only ever sees a sample captured before this edge.
            if (period_start) duty <= pend_q;
            duty_valid <= period_start;
        end
    end

    always_comb begin
        st_d    = st_q;
        theta_d = theta_q;
        presc_d = presc_q;
        cyc_d   = cyc_q;
        pause_d = pause_q;
        bd_d    = 1'b0;
        case (st_q)
            IDLE: begin
                theta_d = '0;
                presc_d = '0;
                cyc_d   = '0;
                pause_d = '0;
                if (enable) st_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    st_d    = IDLE;
                    theta_d = '0;
                    presc_d = '0;
                    cyc_d   = '0;
                    pause_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    theta_d = theta_q + 8'd1;
                    if (theta_q == 8'd255) begin
                        cyc_d = cyc_q + 1'b1;
                        if (CYCLES_PER_BURST != 0 && cyc_d == CYC_TARGET) begin
                            st_d    = PAUSE;
                            bd_d    = 1'b1;
                            cyc_d   = '0;
                            pause_d = '0;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                theta_d = '0;
                presc_d = '0;
                if (!enable) begin
                    st_d    = IDLE;
                    cyc_d   = '0;
                    pause_d = '0;
                end else if (pause_q == PAUSE_LAST) begin
                    st_d    = RUN;
                    pause_d = '0;
                end else begin
                    pause_d = pause_q + 32'd1;
                end
            end
            default: begin
                st_d    = IDLE;
                theta_d = '0;
                presc_d = '0;
                cyc_d   = '0;
                pause_d = '0;
            end
        endcase
        // Pending is cleared on the same edge that leaves RUN, so IDLE/PAUSE
        // never carry a stale sample.
        pend_d = (st_d == RUN) ? sine_rom(idx) : 8'd0;
    end

    assign theta = theta_q;
    assign state = st_q;

endmodule
